// File: rtl/mont_arbiter.sv
// Round-robin arbiter sharing one montgomery multiplier between two requesters.
// Latches the winner's operands, sequences clear/start, and returns a registered result.
module mont_arbiter #(
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] m0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] m1,
    output logic             ack0,
    output logic             ack1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] res,
    output logic             mont_resetn,
    output logic             mont_start,
    output logic [WIDTH-1:0] mont_a,
    output logic [WIDTH-1:0] mont_b,
    output logic [WIDTH-1:0] mont_m,
    input  logic [WIDTH-1:0] mont_result,
    input  logic             mont_done
);

    typedef enum logic [2:0] {StIdle, StClr, StStart, StBusy, StDone} state_t;

    state_t state;
    logic   owner;
    logic   last_served;
    logic   pick;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = ~last_served;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= StIdle;
            owner       <= 1'b0;
            last_served <= 1'b1;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            res         <= '0;
            mont_a      <= '0;
            mont_b      <= '0;
            mont_m      <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        owner  <= pick;
                        mont_a <= pick ? a1 : a0;
                        mont_b <= pick ? b1 : b0;
                        mont_m <= pick ? m1 : m0;
                        state  <= StClr;
                    end
                end
                StClr:   state <= StStart;
                StStart: state <= StBusy;
                StBusy: begin
                    // A done left over from the previous operation is cleared in StClr.
                    if (mont_done) begin
                        res   <= mont_result;
                        ack0  <= ~owner;
                        ack1  <= owner;
                        state <= StDone;
                    end
                end
                StDone: begin
                    last_served <= owner;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign gnt0        = (state != StIdle) && !owner;
    assign gnt1        = (state != StIdle) && owner;
    assign mont_resetn = resetn && (state != StClr);
    assign mont_start  = (state == StStart);

endmodule

// File: tb/tb_mont_arbiter.sv
// Bench for mont_arbiter: stub multiplier with fixed latency plus an ack scoreboard.
module tb_mont_arbiter;

    localparam int unsigned W   = 512;
    localparam int unsigned LAT = 10;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, m0 = '0, a1 = '0, b1 = '0, m1 = '0;
    logic         ack0, ack1, gnt0, gnt1;
    logic [W-1:0] res;
    logic         mont_resetn, mont_start;
    logic [W-1:0] mont_a, mont_b, mont_m;
    logic [W-1:0] mont_result = '0;
    logic         mont_done = 1'b0;

    typedef struct {
        bit           who;
        logic [W-1:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    int   errors = 0;
    int   checks = 0;

    mont_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .m0(m0), .a1(a1), .b1(b1), .m1(m1),
        .ack0(ack0), .ack1(ack1), .gnt0(gnt0), .gnt1(gnt1), .res(res),
        .mont_resetn(mont_resetn), .mont_start(mont_start),
        .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done)
    );

    always #5 clk = ~clk;

    // Stub multiplier: done rises LAT cycles after start and holds until reset.
    logic [3:0] cnt = '0;
    logic       busy = 1'b0;
    always @(posedge clk) begin
        if (!mont_resetn) begin
            mont_done <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else if (mont_start) begin
            busy <= 1'b1;
            cnt  <= 4'd1;
        end else if (busy) begin
            if (cnt == 4'(LAT - 1)) begin
                mont_done   <= 1'b1;
                mont_result <= (mont_a * mont_b) % mont_m;
                busy        <= 1'b0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (ack0 || ack1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack ack0=%0b ack1=%0b res=%0d, required no ack",
                         ack0, ack1, res);
            end else begin
                popped = sb.pop_front();
                if (ack1 !== popped.who || ack0 === ack1 || res !== popped.val) begin
                    errors++;
                    $display("FAIL sb_ack ack0=%0b ack1=%0b res=%0d, required owner=%0d res=%0d",
                             ack0, ack1, res, popped.who, popped.val);
                end
            end
        end
    end

    task automatic drain(input string name);
        bit fin = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            if (sb.size() == 0 && !req0 && !req1) begin
                fin = 1'b1;
                break;
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d, required 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic single_op(input bit who, input logic [W-1:0] a, b, m, expv,
                             output int g, output int rc, output int oth, output bit ok);
        g = 0; rc = 0; oth = 0; ok = 1'b0;
        if (who) begin a1 = a; b1 = b; m1 = m; req1 = 1'b1; end
        else     begin a0 = a; b0 = b; m0 = m; req0 = 1'b1; end
        sb.push_back('{who, expv});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (who ? gnt1 : gnt0) g++;
            if (!mont_resetn) rc++;
            if (who ? ack0 : ack1) oth++;
            if (who ? ack1 : ack0) begin
                ok = 1'b1;
                req0 = 1'b0;
                req1 = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt0, gnt1, ack0, ack1, mont_start, mont_resetn} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl gnt0/gnt1/ack0/ack1/start/mresetn=%b, required 000000",
                     {gnt0, gnt1, ack0, ack1, mont_start, mont_resetn});
        end
        checks++;
        if (res !== '0 || mont_a !== '0 || mont_b !== '0 || mont_m !== '0) begin
            errors++;
            $display("FAIL reset_data res=%0d mont_a=%0d, required 0", res, mont_a);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (mont_resetn !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release mont_resetn=%b gnt0=%b, required 1 0", mont_resetn, gnt0);
        end
    endtask

    task automatic test_single();
        int g, rc, oth;
        bit ok;
        single_op(1'b0, 3, 5, 7, 1, g, rc, oth, ok);
        checks++;
        if (!ok || g != 13) begin
            errors++;
            $display("FAIL single_gnt ok=%0b gnt0_cycles=%0d, required 1 13", ok, g);
        end
        checks++;
        if (oth != 0 || rc != 1) begin
            errors++;
            $display("FAIL single_misc ack1=%0d mresetn_low=%0d, required 0 1", oth, rc);
        end
        checks++;
        if (res !== 1 || ack0 !== 1'b0 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL single_after res=%0d ack0=%b gnt0=%b, required 1 0 0", res, ack0, gnt0);
        end
    endtask

    task automatic test_tie();
        int na = -1, ng = -1, g, rc, oth;
        bit ok;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        a0 = 2; b0 = 3; m0 = 11;
        a1 = 4; b1 = 5; m1 = 13;
        sb.push_back('{1'b0, 6});
        sb.push_back('{1'b1, 7});
        req0 = 1'b1; req1 = 1'b1;
        for (int n = 1; n < 200; n++) begin
            @(negedge clk);
            if (ack0) begin na = n; req0 = 1'b0; end
            if (gnt1 && ng < 0) ng = n;
            if (ack1) begin req1 = 1'b0; break; end
        end
        checks++;
        if (na != 13 || ng != na + 2) begin
            errors++;
            $display("FAIL tie_order ack0_cycle=%0d gnt1_cycle=%0d, required 13 15", na, ng);
        end
        drain("tie1");
        // Serve req0 alone so the next tie must go to req1.
        single_op(1'b0, 6, 7, 9, 6, g, rc, oth, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tie_solo ack0 seen=%0b, required 1", ok);
        end
        a0 = 5; b0 = 5; m0 = 7;
        a1 = 3; b1 = 4; m1 = 5;
        sb.push_back('{1'b1, 2});
        sb.push_back('{1'b0, 4});
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL tie2_gnt gnt0=%b gnt1=%b, required 0 1", gnt0, gnt1);
        end
        drain("tie2");
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        a0 = 2; b0 = 2; m0 = 3;
        sb.push_back('{1'b0, 1});
        req0 = 1'b1;
        repeat (4) @(negedge clk);
        a1 = 6; b1 = 5; m1 = 7;
        req1 = 1'b1;
        sb.push_back('{1'b1, 2});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack0) begin seen = 1'b1; req0 = 1'b0; break; end
        end
        @(negedge clk);
        a0 = 3; b0 = 3; m0 = 5;
        req0 = 1'b1;
        sb.push_back('{1'b0, 4});
        @(negedge clk);
        checks++;
        if (!seen || gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gnt ack0_seen=%0b gnt0=%b gnt1=%b, required 1 0 1", seen, gnt0, gnt1);
        end
        drain("b2b");
    endtask

    task automatic test_operand_change();
        a1 = 9; b1 = 2; m1 = 23;
        sb.push_back('{1'b1, 18});
        req1 = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL opchg_gnt gnt1=%b, required 1", gnt1);
        end
        @(negedge clk);
        a1 = 4;
        repeat (3) @(negedge clk);
        checks++;
        if (mont_a !== 9) begin
            errors++;
            $display("FAIL opchg_latch mont_a=%0d, required 9", mont_a);
        end
        drain("opchg");
        checks++;
        if (res !== 18) begin
            errors++;
            $display("FAIL opchg_res res=%0d, required 18", res);
        end
    endtask

    task automatic test_stale_done();
        int g, rc, oth;
        bit ok;
        single_op(1'b0, 10, 10, 11, 1, g, rc, oth, ok);
        checks++;
        if (!ok || g != 13 || rc != 1) begin
            errors++;
            $display("FAIL stale_done ok=%0b gnt0_cycles=%0d mresetn_low=%0d, required 1 13 1",
                     ok, g, rc);
        end
    endtask

    task automatic test_reset_mid_busy();
        int acks = 0, g, rc, oth;
        bit ok;
        a0 = 7; b0 = 8; m0 = 9;
        req0 = 1'b1;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        req0   = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || res !== '0) begin
            errors++;
            $display("FAIL midrst_state gnt0=%b gnt1=%b res=%0d, required 0 0 0", gnt0, gnt1, res);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL midrst_noack acks=%0d, required 0", acks);
        end
        single_op(1'b0, 7, 8, 9, 2, g, rc, oth, ok);
        checks++;
        if (!ok || g != 13 || res !== 2) begin
            errors++;
            $display("FAIL midrst_recover ok=%0b gnt0_cycles=%0d res=%0d, required 1 13 2",
                     ok, g, res);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_operand_change();
        test_stale_done();
        test_reset_mid_busy();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover pending=%0d, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
